// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the data-memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int STARVE_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_EX = 1'b1
    } owner_t;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one data-memory port between fetch (reads) and execute
//               (loads/stores); execute has priority, fetch is starvation-
//               protected. Optional statistics counters: MEM_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        ex_req,
    input  logic        ex_we,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [7:0]  ex_mask,
    output logic        ex_ready,
    output logic        ex_rvalid,
    output logic [31:0] ex_rdata,
    output logic        ex_stall,

    input  logic        flush,

`ifdef MEM_ARB_STATS_EN
    output logic [31:0] stat_if_cnt,
    output logic [31:0] stat_ex_cnt,
    output logic [31:0] stat_starve_cnt,
`endif

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_mask,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam logic [STARVE_CNT_W-1:0] c_starve_limit = STARVE_CNT_W'(STARVE_LIMIT);

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    owner_t                  r_owner;
    logic [STARVE_CNT_W-1:0] r_starve_cnt;
    logic                    r_drop;

    logic                    r_mem_req;
    logic                    r_mem_we;
    logic [31:0]             r_mem_addr;
    logic [31:0]             r_mem_wdata;
    logic [7:0]              r_mem_mask;

    logic                    w_idle;
    logic                    w_if_win;
    logic                    w_ex_win;
    logic                    w_forced;
    logic                    w_resp_valid;

    // Arbitration is only live in IDLE and out of reset, so readies never
    // glitch high while the async reset is held.
    always_comb begin
        w_idle   = (r_state == IDLE) && reset;
        w_if_win = w_idle && if_req && (!ex_req || (r_starve_cnt == c_starve_limit));
        w_ex_win = w_idle && ex_req && !w_if_win;
        w_forced = w_if_win && ex_req;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_if_win || w_ex_win) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    w_state_nxt = r_mem_we ? IDLE : RESP;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner     <= OWN_EX;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_mask  <= '0;
        end else if (w_if_win) begin
            r_owner     <= OWN_IF;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= if_addr;
            r_mem_wdata <= '0;
            r_mem_mask  <= '0;
        end else if (w_ex_win) begin
            r_owner     <= OWN_EX;
            r_mem_req   <= 1'b1;
            r_mem_we    <= ex_we;
            r_mem_addr  <= ex_addr;
            r_mem_wdata <= ex_wdata;
            r_mem_mask  <= ex_we ? ex_mask : 8'h00;
        end else if ((r_state == REQ) && mem_gnt) begin
            r_mem_req   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve_cnt <= '0;
        end else if (w_if_win) begin
            r_starve_cnt <= '0;
        end else if (w_ex_win && if_req && (r_starve_cnt != c_starve_limit)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // A flush only matters once fetch owns an issued transaction; the memory
    // side still completes, only the response is swallowed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop <= 1'b0;
        end else if (w_state_nxt == IDLE) begin
            r_drop <= 1'b0;
        end else if (flush && (r_owner == OWN_IF) && (r_state != IDLE)) begin
            r_drop <= 1'b1;
        end
    end

    assign w_resp_valid = (r_state == RESP) && mem_rvalid;

    assign if_ready  = w_if_win;
    assign ex_ready  = w_ex_win;
    assign ex_stall  = reset && ex_req && !w_ex_win;
    assign if_rvalid = w_resp_valid && (r_owner == OWN_IF) && !r_drop && !flush;
    assign ex_rvalid = w_resp_valid && (r_owner == OWN_EX);
    assign if_rdata  = mem_rdata;
    assign ex_rdata  = mem_rdata;

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_mask  = r_mem_mask;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] r_stat_if_cnt;
    logic [31:0] r_stat_ex_cnt;
    logic [31:0] r_stat_starve_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stat_if_cnt     <= '0;
            r_stat_ex_cnt     <= '0;
            r_stat_starve_cnt <= '0;
        end else begin
            if (w_if_win) r_stat_if_cnt     <= r_stat_if_cnt + 32'd1;
            if (w_ex_win) r_stat_ex_cnt     <= r_stat_ex_cnt + 32'd1;
            if (w_forced) r_stat_starve_cnt <= r_stat_starve_cnt + 32'd1;
        end
    end

    assign stat_if_cnt     = r_stat_if_cnt;
    assign stat_ex_cnt     = r_stat_ex_cnt;
    assign stat_starve_cnt = r_stat_starve_cnt;
`else
    logic w_unused_forced;
    assign w_unused_forced = w_forced;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed, table-driven bench for mem_port_arbiter
//               (STARVE_LIMIT=4); MEM_ARB_STATS_EN also checks the counters.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ready, if_rvalid;
    logic [31:0] if_rdata;
    logic        ex_req = 1'b0, ex_we = 1'b0;
    logic [31:0] ex_addr = '0, ex_wdata = '0;
    logic [7:0]  ex_mask = '0;
    logic        ex_ready, ex_rvalid, ex_stall;
    logic [31:0] ex_rdata;
    logic        flush = 1'b0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [7:0]  mem_mask;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_if_cnt, stat_ex_cnt, stat_starve_cnt;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ex_req(ex_req), .ex_we(ex_we), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_mask(ex_mask), .ex_ready(ex_ready), .ex_rvalid(ex_rvalid),
        .ex_rdata(ex_rdata), .ex_stall(ex_stall), .flush(flush),
`ifdef MEM_ARB_STATS_EN
        .stat_if_cnt(stat_if_cnt), .stat_ex_cnt(stat_ex_cnt),
        .stat_starve_cnt(stat_starve_cnt),
`endif
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    // e_ctl = {if_ready, ex_ready, if_rvalid, ex_rvalid, ex_stall, mem_req}
    typedef struct {
        string       nm;
        logic        if_req;
        logic [31:0] if_addr;
        logic        ex_req, ex_we;
        logic [31:0] ex_addr, ex_wdata;
        logic [7:0]  ex_mask;
        logic        flush, gnt, rvalid;
        logic [31:0] rdata;
        logic [5:0]  e_ctl;
        logic        e_we;
        logic [7:0]  e_mask;
        logic [31:0] e_addr, e_wdata;
    } vec_t;

    vec_t vecs[$];

    int n_checks = 0;
    int n_err    = 0;
    int n_if     = 0;
    int n_ex     = 0;
    int n_forced = 0;

    logic        s_if_req = 0, s_ex_req = 0, s_ex_we = 0;
    logic [31:0] s_if_addr = 0, s_ex_addr = 0, s_ex_wdata = 0;
    logic [7:0]  s_ex_mask = 0;
    logic        m_we = 0;
    logic [7:0]  m_mask = 0;
    logic [31:0] m_addr = 0, m_wdata = 0;

    task automatic add(input string nm, input logic fl, input logic gnt,
                       input logic rv, input logic [31:0] rd, input logic [5:0] ctl);
        vec_t v;
        v.nm = nm; v.if_req = s_if_req; v.if_addr = s_if_addr;
        v.ex_req = s_ex_req; v.ex_we = s_ex_we; v.ex_addr = s_ex_addr;
        v.ex_wdata = s_ex_wdata; v.ex_mask = s_ex_mask;
        v.flush = fl; v.gnt = gnt; v.rvalid = rv; v.rdata = rd;
        v.e_ctl = ctl; v.e_we = m_we; v.e_mask = m_mask;
        v.e_addr = m_addr; v.e_wdata = m_wdata;
        vecs.push_back(v);
        if (ctl[5]) n_if++;
        if (ctl[4]) n_ex++;
        if (ctl[5] && s_ex_req) n_forced++;
    endtask

    task automatic set_mem(input logic we, input logic [7:0] mask,
                           input logic [31:0] addr, input logic [31:0] wdata);
        m_we = we; m_mask = mask; m_addr = addr; m_wdata = wdata;
    endtask

    task automatic check(input string nm, input logic [142:0] act, input logic [142:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [142:0] obs();
        return {if_ready, ex_ready, if_rvalid, ex_rvalid, ex_stall, mem_req, mem_we,
                mem_mask, mem_addr, mem_wdata, if_rdata, ex_rdata};
    endfunction

    function automatic logic [46:0] obs_ctl();
        return {if_ready, ex_ready, if_rvalid, ex_rvalid, ex_stall, mem_req, mem_we,
                mem_mask, mem_addr};
    endfunction

    initial begin
        // Fetch-only read at 0x100
        s_if_req = 1; s_if_addr = 32'h100;
        add("f_acc", 0, 0, 0, 0, 6'b100000);
        s_if_req = 0; set_mem(0, 8'h00, 32'h100, 0);
        add("f_req", 0, 1, 0, 0, 6'b000001);
        add("f_rsp", 0, 0, 1, 32'hDEADBEEF, 6'b001000);

        // Store with grant arriving on the third REQ cycle
        s_ex_req = 1; s_ex_we = 1; s_ex_addr = 32'h40; s_ex_wdata = 32'h12345678; s_ex_mask = 8'h0F;
        add("st_acc", 0, 0, 0, 0, 6'b010000);
        s_ex_req = 0; set_mem(1, 8'h0F, 32'h40, 32'h12345678);
        add("st_hold1", 0, 0, 0, 0, 6'b000001);
        add("st_hold2", 0, 0, 0, 0, 6'b000001);
        add("st_gnt",   0, 1, 0, 0, 6'b000001);
        add("st_idle_stray_rv", 0, 0, 1, 32'hAAAA5555, 6'b000000);

        // Both requesters held: EX x4, forced IF, EX x4, forced IF
        s_ex_we = 0; s_ex_wdata = 0; s_ex_mask = 0; s_ex_addr = 32'h200;
        s_ex_req = 1; s_if_req = 1; s_if_addr = 32'h300;
        for (int r = 0; r < 10; r++) begin
            if (r == 4 || r == 9) begin
                add("sv_if_idle", 0, 0, 0, 0, 6'b100010);
                set_mem(0, 8'h00, 32'h300, 0);
                add("sv_if_req", 0, 1, 0, 0, 6'b000011);
                add("sv_if_rsp", 0, 0, 1, 32'hF0000000 + r, 6'b001010);
            end else begin
                add("sv_ex_idle", 0, 0, 0, 0, 6'b010000);
                set_mem(0, 8'h00, 32'h200, 0);
                add("sv_ex_req", 0, 1, 0, 0, 6'b000011);
                add("sv_ex_rsp", 0, 0, 1, 32'hE0000000 + r, 6'b000110);
            end
        end
        s_ex_req = 0; s_if_req = 0;

        // Flush one cycle before the response
        s_if_req = 1; s_if_addr = 32'h500;
        add("fl_acc", 0, 0, 0, 0, 6'b100000);
        s_if_req = 0; set_mem(0, 8'h00, 32'h500, 0);
        add("fl_req", 0, 1, 0, 0, 6'b000001);
        add("fl_pulse", 1, 0, 0, 0, 6'b000000);
        add("fl_dropped", 0, 0, 1, 32'h11111111, 6'b000000);
        // Flush in IDLE does not affect the newly accepted fetch
        s_if_req = 1; s_if_addr = 32'h504;
        add("fl_idle_acc", 1, 0, 0, 0, 6'b100000);
        s_if_req = 0; set_mem(0, 8'h00, 32'h504, 0);
        add("f2_req", 0, 1, 0, 0, 6'b000001);
        add("f2_rsp", 0, 0, 1, 32'h22222222, 6'b001000);
        // rvalid during REQ ignored; flush coincident with rvalid suppresses
        s_if_req = 1; s_if_addr = 32'h508;
        add("f3_acc", 0, 0, 0, 0, 6'b100000);
        s_if_req = 0; set_mem(0, 8'h00, 32'h508, 0);
        add("f3_req_rv", 0, 0, 1, 32'h55555555, 6'b000001);
        add("f3_gnt", 0, 1, 0, 0, 6'b000001);
        add("f3_rsp_flush", 1, 0, 1, 32'h33333333, 6'b000000);
        // Execute load is not gated by flush
        s_ex_req = 1; s_ex_addr = 32'h600;
        add("x_acc", 0, 0, 0, 0, 6'b010000);
        s_ex_req = 0; set_mem(0, 8'h00, 32'h600, 0);
        add("x_req", 1, 1, 0, 0, 6'b000001);
        add("x_rsp", 1, 0, 1, 32'h44444444, 6'b000100);

        // Reset state: requests present but everything must stay quiet
        if_req = 1; ex_req = 1;
        repeat (2) @(negedge clk);
        #1 check("reset_state", obs(), 143'd0);
        if_req = 0; ex_req = 0;
        reset = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            if_req = vecs[i].if_req;     if_addr = vecs[i].if_addr;
            ex_req = vecs[i].ex_req;     ex_we = vecs[i].ex_we;
            ex_addr = vecs[i].ex_addr;   ex_wdata = vecs[i].ex_wdata;
            ex_mask = vecs[i].ex_mask;   flush = vecs[i].flush;
            mem_gnt = vecs[i].gnt;       mem_rvalid = vecs[i].rvalid;
            mem_rdata = vecs[i].rdata;
            #1;
            check(vecs[i].nm, obs(),
                  {vecs[i].e_ctl, vecs[i].e_we, vecs[i].e_mask, vecs[i].e_addr,
                   vecs[i].e_wdata, vecs[i].rdata, vecs[i].rdata});
        end

`ifdef MEM_ARB_STATS_EN
        check("stat_if",     {111'd0, stat_if_cnt},     {111'd0, 32'(n_if)});
        check("stat_ex",     {111'd0, stat_ex_cnt},     {111'd0, 32'(n_ex)});
        check("stat_starve", {111'd0, stat_starve_cnt}, {111'd0, 32'(n_forced)});
`endif

        // Reset asserted mid-transaction (RESP), then a stale response
        @(negedge clk);
        flush = 0; mem_rvalid = 0; mem_gnt = 0; mem_rdata = 0;
        if_req = 1; if_addr = 32'h700;
        #1 check("rst_seq_acc", {96'd0, obs_ctl()}, {96'd0, 1'b1, 6'b0, 8'h00, 32'h600});
        @(negedge clk);
        if_req = 0; mem_gnt = 1;
        #1 check("rst_seq_req", {96'd0, obs_ctl()}, {96'd0, 6'b000001, 1'b0, 8'h00, 32'h700});
        @(negedge clk);
        mem_gnt = 0; if_req = 1; ex_req = 1;
        #2 reset = 1'b0;
        #1 check("rst_async", obs(), 143'd0);
        @(negedge clk);
        #1 check("rst_held", obs(), 143'd0);
`ifdef MEM_ARB_STATS_EN
        check("stat_rst", {47'd0, stat_if_cnt, stat_ex_cnt, stat_starve_cnt}, 143'd0);
`endif
        if_req = 0; ex_req = 0; reset = 1'b1;
        mem_rvalid = 1; mem_rdata = 32'hBADBAD00;
        #1 check("rst_stale_rv", {96'd0, obs_ctl()}, 143'd0);
        @(negedge clk);
        mem_rvalid = 0; ex_req = 1; ex_we = 0; ex_addr = 32'h800;
        #1 check("post_rst_acc", {96'd0, obs_ctl()}, {96'd0, 7'b0100000, 8'h00, 32'h0});
        @(negedge clk);
        ex_req = 0; mem_gnt = 1;
        #1 check("post_rst_req", {96'd0, obs_ctl()}, {96'd0, 7'b0000010, 8'h00, 32'h800});
        @(negedge clk);
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h99;
        #1 check("post_rst_rsp", {64'd0, obs_ctl(), ex_rdata},
                 {64'd0, 7'b0001000, 8'h00, 32'h800, 32'h99});
        @(negedge clk);
        mem_rvalid = 0;
        #1 check("post_rst_idle", {96'd0, obs_ctl()}, {96'd0, 7'b0000000, 8'h00, 32'h800});
`ifdef MEM_ARB_STATS_EN
        check("stat_post_rst", {47'd0, stat_if_cnt, stat_ex_cnt, stat_starve_cnt},
              {47'd0, 32'd0, 32'd1, 32'd0});
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
